// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared hazard-control types and the pipeline-register strobe bundle
package riscv_pipe_pkg;
    typedef enum logic {HZ_RUN, HZ_MD_BUSY} hz_state_t;
    localparam logic [4:0] REG_X0 = 5'd0;
    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_flush;
        logic ex_mem_bubble;
    } hz_strobe_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit event counter that holds at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count <= '0;
        else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use / branch / MUL-DIV stall-flush strobes plus saturating perf counters
module hazard_stall_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IF_ID_Rs1,
    input  logic [4:0]       IF_ID_Rs2,
    input  logic [4:0]       ID_EX_Rd,
    input  logic             ID_EX_MemRead,
    input  logic             ID_EX_MulDiv,
    input  logic             EX_Branch_Taken,
    output logic             PC_Stall,
    output logic             IF_ID_Stall,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Stall,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Bubble,
    output logic             MD_Busy,
    output logic [CNT_W-1:0] Stall_Count,
    output logic [CNT_W-1:0] Flush_Count
);
    localparam int MW = MD_LATENCY > 2 ? $clog2(MD_LATENCY) : 1;
    localparam logic [MW-1:0] MD_INIT = MW'(MD_LATENCY > 1 ? MD_LATENCY - 2 : 0);
    localparam hz_strobe_t MD_HOLD = '{pc_stall: 1'b1, if_id_stall: 1'b1, if_id_flush: 1'b0,
                                       id_ex_stall: 1'b1, id_ex_flush: 1'b0, ex_mem_bubble: 1'b1};
    hz_state_t  state, state_nxt;
    logic [MW-1:0] md_cnt, md_nxt;
    hz_strobe_t st, st_raw;
    logic       load_use;
    assign load_use = ID_EX_MemRead && ID_EX_Rd != REG_X0 &&
                      (ID_EX_Rd == IF_ID_Rs1 || ID_EX_Rd == IF_ID_Rs2);
    always_comb begin
        st_raw    = '0;
        state_nxt = state;
        md_nxt    = md_cnt;
        if (state == HZ_RUN) begin
            if (EX_Branch_Taken) begin
                st_raw.if_id_flush = 1'b1;
                st_raw.id_ex_flush = 1'b1;
            end else if (ID_EX_MulDiv && MD_LATENCY > 1) begin
                st_raw    = MD_HOLD;
                state_nxt = HZ_MD_BUSY;
                md_nxt    = MD_INIT;
            end else if (load_use) begin
                st_raw.pc_stall    = 1'b1;
                st_raw.if_id_stall = 1'b1;
                st_raw.id_ex_flush = 1'b1;
            end
        end else if (md_cnt != '0) begin
            st_raw = MD_HOLD;
            md_nxt = md_cnt - 1'b1;
        end else begin
            state_nxt = HZ_RUN;
        end
    end
    // strobes must be quiet for the whole time reset is held, not just after the next edge
    assign st = rst_n ? st_raw : '0;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state  <= HZ_RUN;
            md_cnt <= '0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_nxt;
        end
    assign PC_Stall      = st.pc_stall;
    assign IF_ID_Stall   = st.if_id_stall;
    assign IF_ID_Flush   = st.if_id_flush;
    assign ID_EX_Stall   = st.id_ex_stall;
    assign ID_EX_Flush   = st.id_ex_flush;
    assign EX_MEM_Bubble = st.ex_mem_bubble;
    assign MD_Busy       = rst_n && state == HZ_MD_BUSY;
    sat_counter #(.W(CNT_W)) u_stall_cnt (.clk(clk), .rst_n(rst_n), .inc(st.pc_stall), .count(Stall_Count));
    sat_counter #(.W(CNT_W)) u_flush_cnt (.clk(clk), .rst_n(rst_n), .inc(st.if_id_flush), .count(Flush_Count));
endmodule
